cdc_hs_tx_ctrl: RTL
===================

Name: cdc_hs_tx_ctrl

Overview:
Source-side controller for a 4-phase req/ack bus transfer across a clock-domain boundary in the multi-clock system. It accepts a word from a local requester via a valid/ready handshake and holds it stable on XFER_DATA. It then sequences XFER_REQ against the acknowledge returning from the destination domain. The acknowledge is re-timed through an internal NUM_STAGES flop synchronizer before any decision is made on it.

Parameters:
BUS_WIDTH, 8, width of transferred data word
NUM_STAGES, 2, synchronizer depth on XFER_ACK_ASYNC (legal >= 2)
TIMEOUT_CYCLES, 255, CLK cycles allowed in WAIT_ACK_HI before abort (used only with CDC_HS_TIMEOUT_EN)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-low
SRC_DATA  input  BUS_WIDTH  word to transfer
SRC_VALID  input  1  requester has a word
SRC_READY  output  1  controller can accept a word this cycle
XFER_DATA  output  BUS_WIDTH  registered data to destination domain, stable while XFER_REQ is high
XFER_REQ  output  1  registered request to destination domain
XFER_ACK_ASYNC  input  1  acknowledge from destination domain, asynchronous to CLK
BUSY  output  1  high in any state other than IDLE
DONE_PULSE  output  1  one-cycle pulse on handshake completion
TIMEOUT_ERR  output  1  sticky abort flag (only with CDC_HS_TIMEOUT_EN)
ERR_CLR  input  1  synchronous clear of TIMEOUT_ERR (only with CDC_HS_TIMEOUT_EN)

Behaviour:
- Reset (RST low, asynchronous): state IDLE, XFER_REQ=0, XFER_DATA=0, DONE_PULSE=0, TIMEOUT_ERR=0, all synchronizer flops 0, timeout counter 0.
- ack_s = last stage of the NUM_STAGES synchronizer on XFER_ACK_ASYNC. An ACK edge is visible in ack_s NUM_STAGES cycles later. The FSM uses only ack_s.
- SRC_READY = (state==IDLE) && !ack_s. This is combinational from registers and blocks a new request while a stale ACK is still high.
- BUSY = (state!=IDLE).
- FSM states IDLE, WAIT_ACK_HI, WAIT_ACK_LO:
  - IDLE: on SRC_VALID && SRC_READY, latch XFER_DATA<=SRC_DATA, set XFER_REQ<=1, go WAIT_ACK_HI. XFER_REQ rises at the same edge that accepts the word.
  - WAIT_ACK_HI: when ack_s==1, set XFER_REQ<=0, go WAIT_ACK_LO.
  - WAIT_ACK_LO: when ack_s==0, set DONE_PULSE<=1 for exactly one cycle, go IDLE.
- DONE_PULSE is registered and asserted during the first IDLE cycle. SRC_READY may be high in that same cycle, so back-to-back accepts are allowed.
- XFER_DATA changes only on an accept edge and holds through the whole handshake.
- SRC_DATA and SRC_VALID are ignored outside IDLE. SRC_VALID held high across a completion produces exactly one accept per handshake.
- Minimum handshake with an immediately responding destination: 2*NUM_STAGES + 2 CLK cycles from accept to DONE_PULSE, plus destination-side latency.
- ACK glitches or drops while in WAIT_ACK_HI before reaching ack_s have no effect. ACK rising during WAIT_ACK_LO is ignored until ack_s is 0.
- Reset mid-handshake: immediate return to IDLE with REQ low. After reset, the first accept waits for ack_s==0.

Optional Feature:
Macro CDC_HS_TIMEOUT_EN.
- Defined:
  - An 8..32-bit counter clears on entry to WAIT_ACK_HI and increments each cycle in that state.
  - When it reaches TIMEOUT_CYCLES with ack_s still 0: XFER_REQ<=0, TIMEOUT_ERR<=1 (sticky), go WAIT_ACK_LO. That transfer completes without DONE_PULSE.
  - ERR_CLR high clears TIMEOUT_ERR on the next edge. A new timeout in the same cycle wins over ERR_CLR.
- Undefined:
  - No counter, and no TIMEOUT_ERR or ERR_CLR ports.
  - WAIT_ACK_HI waits indefinitely.

Test Plan:
- Basic transfer (BUS_WIDTH=8, NUM_STAGES=2): SRC_DATA=0xA5 with SRC_VALID for 1 cycle; bench raises ACK 1 cycle after REQ and drops it 1 cycle after REQ falls -> XFER_DATA=0xA5 from accept until IDLE, REQ high until 2 cycles after ACK rises, a single DONE_PULSE, SRC_READY low throughout the handshake.
- Back-to-back: SRC_VALID held high with 0x11 then 0x22 -> two accepts; the second occurs in the DONE_PULSE cycle; XFER_DATA sequence is 0x11 then 0x22; no third accept.
- Stale ACK: ACK high at reset release, SRC_VALID=1 -> SRC_READY=0 and REQ=0 until 2 cycles after ACK falls, then accept.
- ACK glitch: 1-cycle-wide ACK pulse shorter than a CLK period between edges while in WAIT_ACK_HI -> no state change, REQ stays 1.
- Reset mid-handshake: assert RST in WAIT_ACK_LO -> REQ=0, XFER_DATA=0, BUSY=0, DONE_PULSE=0 immediately; no DONE_PULSE after release.
- With CDC_HS_TIMEOUT_EN, TIMEOUT_CYCLES=10, ACK never raised -> REQ falls after cycle 10 in WAIT_ACK_HI, TIMEOUT_ERR=1, no DONE_PULSE, IDLE reached; ERR_CLR pulse -> TIMEOUT_ERR=0.

Source files
------------

// File: rtl/cdc_hs_tx_ctrl.sv
// Source side of a 4-phase req/ack transfer into another clock domain; ACK is re-timed locally.
// Optional abort-on-timeout logic is built when CDC_HS_TIMEOUT_EN is defined.
module cdc_hs_tx_ctrl #(
  parameter int BUS_WIDTH      = 8,
  parameter int NUM_STAGES     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] SRC_DATA,
  input  logic                 SRC_VALID,
  output logic                 SRC_READY,
  output logic [BUS_WIDTH-1:0] XFER_DATA,
  output logic                 XFER_REQ,
  input  logic                 XFER_ACK_ASYNC,
  output logic                 BUSY,
`ifdef CDC_HS_TIMEOUT_EN
  output logic                 TIMEOUT_ERR,
  input  logic                 ERR_CLR,
`endif
  output logic                 DONE_PULSE
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACK_HI = 2'd1,
    WAIT_ACK_LO = 2'd2
  } state_t;

  if (NUM_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("cdc_hs_tx_ctrl: NUM_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  state_t                 state_reg;
  logic                   req_reg;
  logic                   done_reg;
  logic [BUS_WIDTH-1:0]   data_reg;
  logic [NUM_STAGES-1:0]  ack_sync_reg;
  logic                   ack_s;
  logic                   src_ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ack_sync_reg <= '0;
    end else begin
      ack_sync_reg <= {ack_sync_reg[NUM_STAGES-2:0], XFER_ACK_ASYNC};
    end
  end

  assign ack_s = ack_sync_reg[NUM_STAGES-1];

  // A stale ACK from an earlier transfer must be seen low before a new word is taken.
  assign src_ready  = (state_reg == IDLE) && !ack_s;
  assign SRC_READY  = src_ready;
  assign BUSY       = (state_reg != IDLE);
  assign XFER_REQ   = req_reg;
  assign XFER_DATA  = data_reg;
  assign DONE_PULSE = done_reg;

`ifdef CDC_HS_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;
  logic             abort_reg;

  assign TIMEOUT_ERR = err_reg;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      done_reg  <= 1'b0;
      data_reg  <= '0;
`ifdef CDC_HS_TIMEOUT_EN
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      abort_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
      // A timeout later in this block overrides the clear.
      if (ERR_CLR) begin
        err_reg <= 1'b0;
      end
`endif
      case (state_reg)
        IDLE: begin
          if (SRC_VALID && src_ready) begin
            data_reg  <= SRC_DATA;
            req_reg   <= 1'b1;
            state_reg <= WAIT_ACK_HI;
`ifdef CDC_HS_TIMEOUT_EN
            cnt_reg   <= '0;
            abort_reg <= 1'b0;
`endif
          end
        end
        WAIT_ACK_HI: begin
          if (ack_s) begin
            req_reg   <= 1'b0;
            state_reg <= WAIT_ACK_LO;
          end
`ifdef CDC_HS_TIMEOUT_EN
          else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            req_reg   <= 1'b0;
            err_reg   <= 1'b1;
            abort_reg <= 1'b1;
            state_reg <= WAIT_ACK_LO;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end
        WAIT_ACK_LO: begin
          if (!ack_s) begin
`ifdef CDC_HS_TIMEOUT_EN
            done_reg  <= !abort_reg;
`else
            done_reg  <= 1'b1;
`endif
            state_reg <= IDLE;
          end
        end
        default: begin
          req_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
